alarm_ctrl: RTL
===============

Name: alarm_ctrl

Overview:
- Downstream neighbour of the clock-logic stage. Consumes the running BCD time (hours/minutes/seconds) and button event pulses.
- Holds a user-settable alarm time, detects the alarm instant, and sequences the ring/idle behaviour.
- Drives the LED bank and a piezo buzzer output.
- Exports the alarm time and its adjust state so the display stage can show and flash it.

Parameters:
- CLK_HZ, 100000000, system clock frequency; documentation only, no logic depends on it.
- TONE_DIV, 25000, clk cycles per buzzer half-period (2 kHz tone at 100 MHz).
- RING_SECS, 60, ring duration in tick_1hz ticks before auto-stop.
- ALARM_RST_H, 8'h06, BCD reset value of alarm hours.
- ALARM_RST_M, 8'h30, BCD reset value of alarm minutes.
- SNOOZE_SECS, 300, snooze length in ticks; used only with ALARM_SNOOZE_EN.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-clk-wide enable pulse, 1 Hz.
- tick_2hz  in  1  one-clk-wide enable pulse, 2 Hz.
- hours  in  8  current time, BCD 00..23.
- minutes  in  8  current time, BCD 00..59.
- seconds  in  8  current time, BCD 00..59.
- alarm_on  in  1  debounced level switch; 1 arms the alarm.
- mode_p  in  1  one-clk pulse; advances the alarm adjust field.
- inc_p  in  1  one-clk pulse; increments the selected field.
- stop_p  in  1  one-clk pulse; silences an active ring.
- alarm_h  out  8  alarm hours, BCD.
- alarm_m  out  8  alarm minutes, BCD.
- adj_sel  out  2  00 none, 01 hours, 10 minutes; 11 never produced.
- ringing  out  1  high while in state RING.
- led  out  8  LED pattern.
- buzzer  out  1  tone output.

Behaviour:
Reset values:
- alarm_h=ALARM_RST_H, alarm_m=ALARM_RST_M, adj_sel=00, state IDLE.
- ringing=0, led=8'h00, buzzer=0; all counters 0; match_q=0.

Adjust:
- mode_p cycles adj_sel 00→01→10→00.
- inc_p with adj_sel=01: alarm_h BCD +1, 23 wraps to 00. With adj_sel=10: alarm_m +1, 59 wraps to 00. With adj_sel=00: ignored.
- mode_p and inc_p in the same cycle: increment applies to the old field, then the field advances.
- BCD carry: low nibble 9 → 0 and high nibble +1.

Match detection:
- match = alarm_on & adj_sel==00 & hours==alarm_h & minutes==alarm_m & seconds==8'h00.
- match_q registers match every clk.
- Trigger = match & ~match_q, i.e. a rising edge, so exactly one trigger per alarm minute regardless of tick alignment.
- Inputs are already synchronous to clk; no extra synchronisation.

State machine:
- IDLE: on trigger → RING on the next clk; ringing goes high 1 clk after trigger; ring_cnt cleared.
- RING: ring_cnt increments on each tick_1hz.
  - ring_cnt reaches RING_SECS-1 and tick_1hz → IDLE.
  - stop_p → IDLE.
  - alarm_on=0 → IDLE.
  - adj_sel becomes nonzero (mode_p) → IDLE.
- Priority within RING: alarm_on=0 > stop_p > mode_p > timeout.
- stop_p in IDLE: no effect.
- stop_p and trigger in the same IDLE cycle: trigger wins, enter RING.
- trigger while in RING: ignored.

Outputs in RING:
- beep_gate toggles on each tick_2hz and starts at 1 on RING entry.
- led = beep_gate ? 8'hFF : 8'h00.
- The tone counter counts 0..TONE_DIV-1 and toggles tone on wrap.
- buzzer = tone & beep_gate.

Outputs outside RING:
- led=00, buzzer=0, tone counter and beep_gate held at 0.

Widths:
- ring_cnt and snooze_cnt are $clog2 of their parameter + 1 bits.
- The tone counter is $clog2(TONE_DIV) bits.

Optional Feature:
ALARM_SNOOZE_EN

Defined:
- Adds state SNOOZE.
- stop_p in RING → SNOOZE; snooze_cnt is cleared.
- In SNOOZE, snooze_cnt increments on tick_1hz; at SNOOZE_SECS-1 with tick → RING, and ring_cnt is cleared.
- In SNOOZE, led[0]=1 and all other LED bits are 0; buzzer=0.
- alarm_on=0 or mode_p in SNOOZE → IDLE.
- stop_p in SNOOZE → IDLE, cancelling the snooze.

Undefined:
- stop_p in RING → IDLE; the SNOOZE state and snooze_cnt are absent.

Decomposition:
- Package alarm_pkg holds:
  - the state encoding IDLE/RING/SNOOZE;
  - adj_sel codes ADJ_NONE/ADJ_HOUR/ADJ_MIN;
  - BCD limit constants 8'h23 and 8'h59.
- One sub-module: bcd_inc_wrap (value, max → next), a combinational BCD incrementer. It is instantiated twice, for hours and minutes.

Test Plan:
- Reset → alarm_h=06, alarm_m=30, adj_sel=00, led=00, buzzer=0, ringing=0.
- Pulse mode_p, then inc_p ×18 → alarm_h 06→23→00. Pulse mode_p, then inc_p ×30 → alarm_m 30→59→00. Pulse mode_p → adj_sel=00.
- Time steps 06:29:59 → 06:30:00 with alarm_on=1 → ringing high 1 clk after the seconds change. With TONE_DIV=4, buzzer toggles every 4 clk while beep_gate=1. After 60 ticks, ringing=0.
- Hold time at 06:30:00 for 500 clk → exactly one trigger. Pulse stop_p at tick 5 → ringing=0 next clk; no re-ring while time stays 06:30:xx.
- Ringing, then alarm_on→0 in the same cycle as stop_p → IDLE next clk, led=00.
- With ALARM_SNOOZE_EN and SNOOZE_SECS=3: stop_p in RING → led=8'h01; after 3 ticks → ringing=1 again.

Source files
------------

// File: rtl/alarm_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | alarm_pkg : shared state encoding, adjust-field codes and BCD limits
// | Rev 1.0
// +---------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    localparam logic [1:0] ADJ_NONE = 2'b00;
    localparam logic [1:0] ADJ_HOUR = 2'b01;
    localparam logic [1:0] ADJ_MIN  = 2'b10;

    localparam logic [7:0] BCD_MAX_HOUR = 8'h23;
    localparam logic [7:0] BCD_MAX_MIN  = 8'h59;

endpackage : alarm_pkg
`default_nettype wire

// File: rtl/bcd_inc_wrap.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | bcd_inc_wrap : combinational two-digit BCD increment, wraps max -> 00
// | Rev 1.0
// +---------------------------------------------------------------------------
module bcd_inc_wrap (
    input  logic [7:0] value,
    input  logic [7:0] max,
    output logic [7:0] next
);

    always_comb begin
        next = 8'h00;
        if (value == max) begin
            next = 8'h00;
        end else if (value[3:0] == 4'd9) begin
            next = {value[7:4] + 4'd1, 4'd0};
        end else begin
            next = {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule : bcd_inc_wrap
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | alarm_ctrl : alarm time setting, match detection, ring sequencing, LED/buzzer
// | Optional snooze state enabled by defining ALARM_SNOOZE_EN.   Rev 1.0
// +---------------------------------------------------------------------------
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int         CLK_HZ      = 100000000,
    parameter int         TONE_DIV    = 25000,
    parameter int         RING_SECS   = 60,
    parameter logic [7:0] ALARM_RST_H = 8'h06,
    parameter logic [7:0] ALARM_RST_M = 8'h30,
    parameter int         SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic [7:0] hours,
    input  logic [7:0] minutes,
    input  logic [7:0] seconds,
    input  logic       alarm_on,
    input  logic       mode_p,
    input  logic       inc_p,
    input  logic       stop_p,
    output logic [7:0] alarm_h,
    output logic [7:0] alarm_m,
    output logic [1:0] adj_sel,
    output logic       ringing,
    output logic [7:0] led,
    output logic       buzzer
);

    localparam int RW = $clog2(RING_SECS) + 1;
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
`ifdef ALARM_SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_SECS) + 1;
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECS - 1);
`endif

    // CLK_HZ is informational; this only flags nonsensical configurations.
    localparam bit CFG_OK = (CLK_HZ > 0) && (TONE_DIV > 0) && (RING_SECS > 0) && (SNOOZE_SECS > 0);
    if (!CFG_OK) begin : g_cfg_invalid
    end

    state_t        state_q, state_d;
    logic [7:0]    alarm_h_q, alarm_h_d, alarm_m_q, alarm_m_d;
    logic [1:0]    adj_sel_q, adj_sel_d;
    logic          match_q, match_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic          tone_q, tone_d, beep_q, beep_d;
    logic          ringing_q, ringing_d, buzzer_q, buzzer_d;
    logic [7:0]    led_q, led_d;
    logic [7:0]    h_next, m_next;
    logic          trigger;
`ifdef ALARM_SNOOZE_EN
    logic [SW-1:0] snooze_cnt_q, snooze_cnt_d;
`endif

    bcd_inc_wrap u_inc_hour (.value(alarm_h_q), .max(BCD_MAX_HOUR), .next(h_next));
    bcd_inc_wrap u_inc_min  (.value(alarm_m_q), .max(BCD_MAX_MIN),  .next(m_next));

    always_comb begin
        alarm_h_d  = alarm_h_q;
        alarm_m_d  = alarm_m_q;
        adj_sel_d  = adj_sel_q;
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        tone_cnt_d = tone_cnt_q;
        tone_d     = tone_q;
        beep_d     = beep_q;
`ifdef ALARM_SNOOZE_EN
        snooze_cnt_d = snooze_cnt_q;
`endif

        // Increment uses the field selected before any same-cycle mode advance.
        if (inc_p && adj_sel_q == ADJ_HOUR) alarm_h_d = h_next;
        if (inc_p && adj_sel_q == ADJ_MIN)  alarm_m_d = m_next;
        if (mode_p) begin
            case (adj_sel_q)
                ADJ_NONE: adj_sel_d = ADJ_HOUR;
                ADJ_HOUR: adj_sel_d = ADJ_MIN;
                default:  adj_sel_d = ADJ_NONE;
            endcase
        end

        match_d = alarm_on && (adj_sel_q == ADJ_NONE) && (hours == alarm_h_q)
                  && (minutes == alarm_m_q) && (seconds == 8'h00);
        trigger = match_d && !match_q;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d    = ST_RING;
                    ring_cnt_d = '0;
                    beep_d     = 1'b1;
                end
            end
            ST_RING: begin
                if (tone_cnt_q == TONE_LAST) begin
                    tone_cnt_d = '0;
                    tone_d     = !tone_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + TW'(1);
                end
                if (tick_2hz) beep_d = !beep_q;
                if (tick_1hz) ring_cnt_d = ring_cnt_q + RW'(1);

                if (!alarm_on) begin
                    state_d = ST_IDLE;
                end else if (stop_p) begin
`ifdef ALARM_SNOOZE_EN
                    state_d      = ST_SNOOZE;
                    snooze_cnt_d = '0;
`else
                    state_d = ST_IDLE;
`endif
                end else if (mode_p) begin
                    state_d = ST_IDLE;
                end else if (tick_1hz && ring_cnt_q == RING_LAST) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (!alarm_on || stop_p || mode_p) begin
                    state_d = ST_IDLE;
                end else if (tick_1hz) begin
                    if (snooze_cnt_q == SNOOZE_LAST) begin
                        state_d    = ST_RING;
                        ring_cnt_d = '0;
                        beep_d     = 1'b1;
                    end else begin
                        snooze_cnt_d = snooze_cnt_q + SW'(1);
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Tone and beep gate only run while ringing.
        if (state_d != ST_RING) begin
            tone_cnt_d = '0;
            tone_d     = 1'b0;
            beep_d     = 1'b0;
        end

        ringing_d = (state_d == ST_RING);
        buzzer_d  = ringing_d && tone_d && beep_d;
        led_d     = (ringing_d && beep_d) ? 8'hFF : 8'h00;
`ifdef ALARM_SNOOZE_EN
        if (state_d == ST_SNOOZE) led_d = 8'h01;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            alarm_h_q  <= ALARM_RST_H;
            alarm_m_q  <= ALARM_RST_M;
            adj_sel_q  <= ADJ_NONE;
            match_q    <= 1'b0;
            ring_cnt_q <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            beep_q     <= 1'b0;
            ringing_q  <= 1'b0;
            buzzer_q   <= 1'b0;
            led_q      <= 8'h00;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            alarm_h_q  <= alarm_h_d;
            alarm_m_q  <= alarm_m_d;
            adj_sel_q  <= adj_sel_d;
            match_q    <= match_d;
            ring_cnt_q <= ring_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            beep_q     <= beep_d;
            ringing_q  <= ringing_d;
            buzzer_q   <= buzzer_d;
            led_q      <= led_d;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q <= snooze_cnt_d;
`endif
        end
    end

    assign alarm_h = alarm_h_q;
    assign alarm_m = alarm_m_q;
    assign adj_sel = adj_sel_q;
    assign ringing = ringing_q;
    assign led     = led_q;
    assign buzzer  = buzzer_q;

endmodule : alarm_ctrl
`default_nettype wire
